// File: rtl/ccu_snoop_collector.sv
//------------------------------------------------------------------------------
// Module      : ccu_snoop_collector
// Description : Snoop fan-out / fan-in stage behind the CCU control FSM.
//               Broadcasts one AC snoop request to every master except the
//               initiator, collects one CR response per snooped port, merges
//               the responses into a single summary, and forwards the CD
//               burst of the lowest-index port that returned data. CD bursts
//               from any other data-returning port are drained and dropped.
// Ports       : clk_i/rst_ni          clock, async active-low reset
//               ac_*                  snoop request from the FSM
//               snp_ac_*              per-port AC broadcast (shared payload)
//               snp_cr_*              per-port CR responses
//               snp_cd_*              per-port CD data
//               rsp_*                 aggregated response to the FSM
//               data_*                forwarded CD stream
// Options     : CCU_SNOOP_TIMEOUT_EN  enables a CR wait limit of
//                                     TimeoutCycles; on expiry the response
//                                     is emitted with rsp_error_o set.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccu_snoop_collector #(
  parameter int unsigned NoMstPorts    = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 256,
  localparam int unsigned IdxWidth     = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // snoop request from the FSM
  input  logic                            ac_valid_i,
  output logic                            ac_ready_o,
  input  logic [AddrWidth-1:0]            ac_addr_i,
  input  logic [3:0]                      ac_snoop_i,
  input  logic [2:0]                      ac_prot_i,
  input  logic [IdxWidth-1:0]             init_idx_i,
  // per-port AC
  output logic [NoMstPorts-1:0]           snp_ac_valid_o,
  input  logic [NoMstPorts-1:0]           snp_ac_ready_i,
  output logic [AddrWidth-1:0]            snp_ac_addr_o,
  output logic [3:0]                      snp_ac_snoop_o,
  output logic [2:0]                      snp_ac_prot_o,
  // per-port CR
  input  logic [NoMstPorts-1:0]           snp_cr_valid_i,
  output logic [NoMstPorts-1:0]           snp_cr_ready_o,
  input  logic [5*NoMstPorts-1:0]         snp_cr_resp_i,
  // per-port CD
  input  logic [NoMstPorts-1:0]           snp_cd_valid_i,
  output logic [NoMstPorts-1:0]           snp_cd_ready_o,
  input  logic [DataWidth*NoMstPorts-1:0] snp_cd_data_i,
  input  logic [NoMstPorts-1:0]           snp_cd_last_i,
  // aggregated response
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic                            rsp_data_avail_o,
  output logic                            rsp_dirty_o,
  output logic                            rsp_shared_o,
  output logic                            rsp_error_o,
  output logic [IdxWidth-1:0]             rsp_src_o,
  // forwarded data
  output logic                            data_valid_o,
  input  logic                            data_ready_i,
  output logic [DataWidth-1:0]            data_o,
  output logic                            data_last_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_RESP  = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  state_e r_state, w_state_nxt;

  logic [AddrWidth-1:0]  r_addr;
  logic [3:0]            r_snoop;
  logic [2:0]            r_prot;
  logic [NoMstPorts-1:0] r_target, r_ac_sent, r_cr_got, r_data_mask;
  logic                  r_avail, r_dirty, r_shared, r_error;
  logic [IdxWidth-1:0]   r_src;

  logic [NoMstPorts-1:0] w_target_new;
  logic [NoMstPorts-1:0] w_rsp_dt, w_rsp_err, w_rsp_dirty, w_rsp_shared, w_rsp_unique;
  logic [NoMstPorts-1:0] w_ac_valid, w_cr_ready, w_cd_ready;
  logic [NoMstPorts-1:0] w_ac_hs, w_cr_hs, w_cd_last_hs, w_dm_snoop;
  logic                  w_ac_ready, w_rsp_valid, w_data_valid, w_data_last;
  logic [DataWidth-1:0]  w_data;
  logic                  w_timeout, w_to_idle;
  logic                  w_unused_was_unique;

  // Lowest set bit of a port mask; callers guarantee the mask is non-zero.
  function automatic logic [IdxWidth-1:0] f_lowest(input logic [NoMstPorts-1:0] m);
    f_lowest = '0;
    for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = IdxWidth'(i);
    end
  endfunction

  // Target mask: every port except the initiator. An out-of-range index
  // matches no port, so nobody is excluded.
  always_comb begin
    w_target_new = '0;
    for (int i = 0; i < int'(NoMstPorts); i++) begin
      w_target_new[i] = (init_idx_i != IdxWidth'(i));
    end
  end

  // Unpack CRRESP fields per port.
  always_comb begin
    w_rsp_dt     = '0;
    w_rsp_err    = '0;
    w_rsp_dirty  = '0;
    w_rsp_shared = '0;
    w_rsp_unique = '0;
    for (int i = 0; i < int'(NoMstPorts); i++) begin
      w_rsp_dt[i]     = snp_cr_resp_i[5*i + 0];
      w_rsp_err[i]    = snp_cr_resp_i[5*i + 1];
      w_rsp_dirty[i]  = snp_cr_resp_i[5*i + 2];
      w_rsp_shared[i] = snp_cr_resp_i[5*i + 3];
      w_rsp_unique[i] = snp_cr_resp_i[5*i + 4];
    end
  end

  // WasUnique carries no meaning for the aggregated summary.
  assign w_unused_was_unique = ^w_rsp_unique;

`ifdef CCU_SNOOP_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
  logic [CntWidth-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (r_state == ST_SNOOP) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TimeoutCycles;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    w_state_nxt  = r_state;
    w_ac_ready   = 1'b0;
    w_ac_valid   = '0;
    w_cr_ready   = '0;
    w_cd_ready   = '0;
    w_ac_hs      = '0;
    w_cr_hs      = '0;
    w_cd_last_hs = '0;
    w_rsp_valid  = 1'b0;
    w_data_valid = 1'b0;
    w_data       = '0;
    w_data_last  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ac_ready = 1'b1;
        if (ac_valid_i) w_state_nxt = (w_target_new == '0) ? ST_RESP : ST_SNOOP;
      end
      ST_SNOOP: begin
        w_ac_valid = r_target & ~r_ac_sent;
        // CR is only taken once the AC for that port has been sent in an
        // earlier cycle.
        w_cr_ready = r_ac_sent & ~r_cr_got;
        w_ac_hs    = w_ac_valid & snp_ac_ready_i;
        w_cr_hs    = w_cr_ready & snp_cr_valid_i;
        if ((r_cr_got | w_cr_hs) == r_target) begin
          w_state_nxt = ST_RESP;
        end
`ifdef CCU_SNOOP_TIMEOUT_EN
        else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready_i) w_state_nxt = (r_data_mask != '0) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        for (int i = 0; i < int'(NoMstPorts); i++) begin
          if (r_data_mask[i]) begin
            if (r_src == IdxWidth'(i)) begin
              w_cd_ready[i] = data_ready_i;
              w_data_valid  = snp_cd_valid_i[i];
              w_data        = snp_cd_data_i[i*DataWidth +: DataWidth];
              w_data_last   = snp_cd_last_i[i];
            end else begin
              w_cd_ready[i] = 1'b1;  // drain and discard
            end
          end
        end
        w_cd_last_hs = w_cd_ready & snp_cd_valid_i & snp_cd_last_i;
        if ((r_data_mask & ~w_cd_last_hs) == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_dm_snoop = r_data_mask | (w_cr_hs & w_rsp_dt);
  assign w_to_idle  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  // Request payload, port masks and response summary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_snoop     <= '0;
      r_prot      <= '0;
      r_target    <= '0;
      r_ac_sent   <= '0;
      r_cr_got    <= '0;
      r_data_mask <= '0;
      r_avail     <= 1'b0;
      r_dirty     <= 1'b0;
      r_shared    <= 1'b0;
      r_error     <= 1'b0;
      r_src       <= '0;
    end else if (w_to_idle) begin
      r_addr      <= '0;
      r_snoop     <= '0;
      r_prot      <= '0;
      r_target    <= '0;
      r_ac_sent   <= '0;
      r_cr_got    <= '0;
      r_data_mask <= '0;
      r_avail     <= 1'b0;
      r_dirty     <= 1'b0;
      r_shared    <= 1'b0;
      r_error     <= 1'b0;
      r_src       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ac_valid_i) begin
            r_addr      <= ac_addr_i;
            r_snoop     <= ac_snoop_i;
            r_prot      <= ac_prot_i;
            r_target    <= w_target_new;
            r_ac_sent   <= '0;
            r_cr_got    <= '0;
            r_data_mask <= '0;
            r_avail     <= 1'b0;
            r_dirty     <= 1'b0;
            r_shared    <= 1'b0;
            r_error     <= 1'b0;
            r_src       <= '0;
          end
        end
        ST_SNOOP: begin
          r_ac_sent   <= r_ac_sent | w_ac_hs;
          r_cr_got    <= r_cr_got | w_cr_hs;
          r_data_mask <= w_dm_snoop;
          // Recomputing from the whole mask keeps the lowest data port even
          // when a lower port reports after a higher one.
          if (w_dm_snoop != '0) r_src <= f_lowest(w_dm_snoop);
          r_avail  <= r_avail  | (|(w_cr_hs & w_rsp_dt));
          r_dirty  <= r_dirty  | (|(w_cr_hs & w_rsp_dirty));
          r_shared <= r_shared | (|(w_cr_hs & w_rsp_shared));
          r_error  <= r_error  | (|(w_cr_hs & w_rsp_err)) | w_timeout;
        end
        ST_DATA: begin
          r_data_mask <= r_data_mask & ~w_cd_last_hs;
        end
        default: begin
        end
      endcase
    end
  end

  assign ac_ready_o       = w_ac_ready;
  assign snp_ac_valid_o   = w_ac_valid;
  assign snp_ac_addr_o    = r_addr;
  assign snp_ac_snoop_o   = r_snoop;
  assign snp_ac_prot_o    = r_prot;
  assign snp_cr_ready_o   = w_cr_ready;
  assign snp_cd_ready_o   = w_cd_ready;
  assign rsp_valid_o      = w_rsp_valid;
  assign rsp_data_avail_o = r_avail;
  assign rsp_dirty_o      = r_dirty;
  assign rsp_shared_o     = r_shared;
  assign rsp_error_o      = r_error;
  assign rsp_src_o        = r_src;
  assign data_valid_o     = w_data_valid;
  assign data_o           = w_data;
  assign data_last_o      = w_data_last;

endmodule

`default_nettype wire
